// File: rtl/emu_mem_pkg.sv
// +-----------------------------------------------------------------------+
// | emu_mem_pkg: shared types and helpers for the memory command engine   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package emu_mem_pkg;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_FETCH_ADD = 2'd2,
    OP_SWAP      = 2'd3
  } emu_mem_op_e;

  // Widest word the helper handles; callers zero-extend and truncate.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] apply_strb(
    input logic [MAX_DATA_WIDTH-1:0] old_w,
    input logic [MAX_DATA_WIDTH-1:0] new_w,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/emu_mem_rsp_fifo.sv
// +-----------------------------------------------------------------------+
// | emu_mem_rsp_fifo: response FIFO with registered head/full/empty       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module emu_mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    remain   = count_q - CW'(do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    head_d   = head_q;
    // The new head bypasses storage when it is the entry being pushed now.
    if (count_d != '0) head_d = (remain == '0) ? push_data_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // full_q reads as set during reset so no command is accepted then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(do_push);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = head_q;

endmodule

`default_nettype wire

// File: rtl/emu_mem_rw_engine.sv
// +-----------------------------------------------------------------------+
// | emu_mem_rw_engine: single-cycle read/write/fetch-add/swap engine      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module emu_mem_rw_engine
  import emu_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int DEPTH          = 256,
  parameter int ID_WIDTH       = 4,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_vld_i,
  output logic                    cmd_rdy_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [ID_WIDTH-1:0]     cmd_id_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  output logic                    rsp_vld_o,
  input  logic                    rsp_rdy_i,
  output logic [ID_WIDTH-1:0]     rsp_id_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_err_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int RSP_W  = ID_WIDTH + 1 + DATA_WIDTH;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [IDX_W-1:0]          idx;
  logic [DATA_WIDTH-1:0]     old_word, new_word, rsp_data;
  logic [MAX_DATA_WIDTH-1:0] old_ext, new_ext;
  logic [MAX_STRB_WIDTH-1:0] strb_ext;
  logic                      accept, in_range, mem_we;
  logic                      fifo_full, fifo_empty;
  logic [RSP_W-1:0]          fifo_head;
  emu_mem_op_e               op;

  assign op       = emu_mem_op_e'(cmd_op_i);
  assign idx      = cmd_addr_i[IDX_W-1:0];
  assign in_range = (cmd_addr_i[ADDR_WIDTH-1:IDX_W] == '0);
  assign old_word = mem_q[idx];
  assign accept   = cmd_vld_i & cmd_rdy_o;

  always_comb begin
    old_ext  = '0;
    new_ext  = '0;
    strb_ext = '0;
    old_ext[DATA_WIDTH-1:0] = old_word;
    new_ext[DATA_WIDTH-1:0] = cmd_wdata_i;
    strb_ext[STRB_W-1:0]    = cmd_strb_i;
    mem_we   = 1'b0;
    new_word = old_word;
    rsp_data = '0;
    case (op)
      OP_READ: rsp_data = old_word;
      OP_WRITE: begin
        mem_we   = 1'b1;
        new_word = DATA_WIDTH'(apply_strb(old_ext, new_ext, strb_ext));
      end
      OP_FETCH_ADD: begin
        mem_we   = 1'b1;
        new_word = old_word + cmd_wdata_i;
        rsp_data = old_word;
      end
      OP_SWAP: begin
        mem_we   = 1'b1;
        new_word = DATA_WIDTH'(apply_strb(old_ext, new_ext, strb_ext));
        rsp_data = old_word;
      end
    endcase
    if (!in_range) begin
      mem_we   = 1'b0;
      rsp_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && mem_we) mem_q[idx] <= new_word;
  end

  emu_mem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (accept),
    .push_data_i ({cmd_id_i, ~in_range, rsp_data}),
    .pop_i       (rsp_rdy_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign cmd_rdy_o = ~fifo_full;
  assign rsp_vld_o = ~fifo_empty;
  assign {rsp_id_o, rsp_err_o, rsp_data_o} = fifo_head;

endmodule

`default_nettype wire
